// File: rtl/npu_pkg.sv
// Shared NPU datapath defaults and saturating/rounding arithmetic helpers.
// Helpers work in a 64-bit signed domain so one copy serves every width up to 62 bits.
package npu_pkg;

   localparam int NPU_DAT_W  = 24;
   localparam int NPU_BIAS_W = 16;
   localparam int NPU_ACC_W  = 32;
   localparam int NPU_OUT_W  = 8;
   localparam int CALC_W     = 64;

   typedef logic signed [CALC_W-1:0] calc_t;

   function automatic calc_t sat_w(input calc_t v, input int w);
      calc_t hi;
      calc_t lo;
      hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
      lo = -(calc_t'(1) <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

   function automatic calc_t sat_acc(input calc_t v, input int w = NPU_ACC_W);
      return sat_w(v, w);
   endfunction

   function automatic calc_t sat_out(input calc_t v, input int w = NPU_OUT_W);
      return sat_w(v, w);
   endfunction

   // Round-half-up arithmetic right shift; the rounding add saturates at width w.
   function automatic calc_t rnd_shift(input calc_t v, input logic [4:0] sh, input int w);
      calc_t t;
      t = v;
      if (sh != 5'd0) t = sat_w(v + (calc_t'(1) <<< (sh - 5'd1)), w);
      return t >>> sh;
   endfunction

endpackage

// File: rtl/npu_quant.sv
// Quantizer: rounding right-shift, optional ReLU and signed saturation, one register stage.
// Shared with the pooling and eltwise paths.
module npu_quant
   import npu_pkg::*;
#(
   parameter int IN_W  = NPU_ACC_W,
   parameter int OUT_W = NPU_OUT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_vld,
   input  logic signed [IN_W-1:0]  in_dat,
   input  logic [4:0]              shift,
   input  logic                    relu_en,
   output logic                    out_vld,
   output logic signed [OUT_W-1:0] out_dat
);

   calc_t r;

   always_comb begin
      r = rnd_shift(calc_t'(in_dat), shift, IN_W);
      if (relu_en && r < 0) r = '0;
      r = sat_out(r, OUT_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         out_dat <= '0;
      end else if (clr) begin
         out_vld <= 1'b0;
      end else begin
         out_vld <= in_vld;
         if (in_vld) out_dat <= OUT_W'(r);
      end
   end

endmodule

// File: rtl/bias_add_act.sv
// Partial-sum accumulation, bias add aligned to bias RAM latency, then quantization.
// One quantized result per output element; no backpressure.
module bias_add_act
   import npu_pkg::*;
#(
   parameter int DAT_W       = NPU_DAT_W,
   parameter int BIAS_W      = NPU_BIAS_W,
   parameter int ACC_W       = NPU_ACC_W,
   parameter int OUT_W       = NPU_OUT_W,
   parameter int BIAS_RD_LAT = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_calc_en,
   input  logic [4:0]               i_part_num,
   input  logic [7:0]               i_output_layers,
   input  logic [4:0]               i_shift,
   input  logic                     i_relu_en,
   input  logic                     i_pe_out_en,
   input  logic signed [DAT_W-1:0]  i_pe_dat,
   input  logic                     i_bias_rd_en,
   input  logic signed [BIAS_W-1:0] i_bias_dat,
   output logic                     o_vld,
   output logic signed [OUT_W-1:0]  o_dat,
   output logic                     o_last,
   output logic                     o_err
);

   localparam int L = BIAS_RD_LAT;

   logic [4:0]              part_max, part_cnt;
   logic [7:0]              ch_max, ch_cnt;
   logic signed [ACC_W-1:0] acc, acc_nxt, sum_al, add_s;
   logic [L:0]              vld_pipe;
   logic [L:1]              rd_pipe;
   calc_t                   bias_x;

   assign part_max = (i_part_num == 5'd0) ? 5'd1 : i_part_num;
   assign ch_max   = (i_output_layers == 8'd0) ? 8'd1 : i_output_layers;
   assign bias_x   = rd_pipe[L] ? calc_t'(i_bias_dat) : calc_t'(0);

   always_comb begin
      acc_nxt = ACC_W'(calc_t'(i_pe_dat));
      if (part_cnt != 5'd1) acc_nxt = ACC_W'(sat_acc(calc_t'(acc) + calc_t'(i_pe_dat), ACC_W));
   end

   // vld_pipe[0]: acc holds a final sum; vld_pipe[L-1]: sum meets bias; vld_pipe[L]: add_s valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc      <= '0;
         part_cnt <= 5'd1;
         vld_pipe <= '0;
         rd_pipe  <= '0;
         add_s    <= '0;
         o_err    <= 1'b0;
      end else if (i_calc_en) begin
         acc      <= '0;
         part_cnt <= 5'd1;
         vld_pipe <= '0;
         rd_pipe  <= '0;
         o_err    <= 1'b0;
      end else begin
         vld_pipe[0] <= 1'b0;
         if (i_pe_out_en) begin
            acc <= acc_nxt;
            if (part_cnt >= part_max) begin
               part_cnt    <= 5'd1;
               vld_pipe[0] <= 1'b1;
            end else begin
               part_cnt <= part_cnt + 5'd1;
            end
         end
         for (int k = 1; k <= L; k++) vld_pipe[k] <= vld_pipe[k-1];
         rd_pipe[1] <= i_bias_rd_en;
         for (int k = 2; k <= L; k++) rd_pipe[k] <= rd_pipe[k-1];
         if (vld_pipe[L-1]) begin
            add_s <= ACC_W'(sat_acc(calc_t'(sum_al) + bias_x, ACC_W));
            if (!rd_pipe[L]) o_err <= 1'b1;
         end
      end
   end

   // The final sum sits in acc for one cycle; longer bias latency needs extra sum stages.
   generate
      if (L == 1) begin : g_nodly
         assign sum_al = acc;
      end else begin : g_dly
         logic signed [ACC_W-1:0] dly [L-1];
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int k = 0; k < L - 1; k++) dly[k] <= '0;
            end else begin
               dly[0] <= acc;
               for (int k = 1; k < L - 1; k++) dly[k] <= dly[k-1];
            end
         end
         assign sum_al = dly[L-2];
      end
   endgenerate

   npu_quant #(
      .IN_W  (ACC_W),
      .OUT_W (OUT_W)
   ) u_quant (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .clr     (i_calc_en),
      .in_vld  (vld_pipe[L]),
      .in_dat  (add_s),
      .shift   (i_shift),
      .relu_en (i_relu_en),
      .out_vld (o_vld),
      .out_dat (o_dat)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ch_cnt <= 8'd1;
         o_last <= 1'b0;
      end else if (i_calc_en) begin
         ch_cnt <= 8'd1;
         o_last <= 1'b0;
      end else begin
         o_last <= 1'b0;
         if (vld_pipe[L]) begin
            o_last <= (ch_cnt >= ch_max);
            ch_cnt <= (ch_cnt >= ch_max) ? 8'd1 : ch_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_bias_add_act.sv
// Directed bench for bias_add_act: one instance at bias latency 1, one at latency 2.
module tb_bias_add_act;

   localparam int DAT_W  = 24;
   localparam int BIAS_W = 16;
   localparam int ACC_W  = 32;
   localparam int OUT_W  = 8;

   logic clk = 1'b0, rst_n = 1'b0, calc_en = 1'b0, relu_en = 1'b0;
   logic pe_out_en = 1'b0, bias_rd_en = 1'b0;
   logic [4:0] part_num = 5'd1, shift = 5'd0;
   logic [7:0] output_layers = 8'd1;
   logic signed [DAT_W-1:0]  pe_dat = '0;
   logic signed [BIAS_W-1:0] bias_req = '0, bp1 = '0, bp2a = '0, bp2b = '0;
   logic vld1, last1, err1, vld2, last2, err2;
   logic signed [OUT_W-1:0] dat1, dat2;

   int cyc = 0, checks = 0, errors = 0;
   int q1_dat[$], q1_cyc[$], q1_last[$];
   int q2_dat[$], q2_cyc[$], q2_last[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bias RAM models: data returned 1 or 2 cycles after the read request.
   always @(posedge clk) begin
      bp1  <= bias_req;
      bp2a <= bias_req;
      bp2b <= bp2a;
   end

   bias_add_act #(.DAT_W(DAT_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .BIAS_RD_LAT(1)) u_l1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_calc_en(calc_en), .i_part_num(part_num),
      .i_output_layers(output_layers), .i_shift(shift), .i_relu_en(relu_en),
      .i_pe_out_en(pe_out_en), .i_pe_dat(pe_dat), .i_bias_rd_en(bias_rd_en), .i_bias_dat(bp1),
      .o_vld(vld1), .o_dat(dat1), .o_last(last1), .o_err(err1)
   );

   bias_add_act #(.DAT_W(DAT_W), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .BIAS_RD_LAT(2)) u_l2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_calc_en(calc_en), .i_part_num(part_num),
      .i_output_layers(output_layers), .i_shift(shift), .i_relu_en(relu_en),
      .i_pe_out_en(pe_out_en), .i_pe_dat(pe_dat), .i_bias_rd_en(bias_rd_en), .i_bias_dat(bp2b),
      .o_vld(vld2), .o_dat(dat2), .o_last(last2), .o_err(err2)
   );

   always @(posedge clk) begin
      #1;
      if (vld1) begin q1_dat.push_back(int'(dat1)); q1_cyc.push_back(cyc); q1_last.push_back(int'(last1)); end
      if (vld2) begin q2_dat.push_back(int'(dat2)); q2_cyc.push_back(cyc); q2_last.push_back(int'(last2)); end
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_r(input int sel, input string tag, input int i, input int ed, input int ec, input int el);
      int d, c, l;
      d = -9999; c = -1; l = -1;
      if (sel == 1 && i < q1_dat.size()) begin d = q1_dat[i]; c = q1_cyc[i]; l = q1_last[i]; end
      if (sel == 2 && i < q2_dat.size()) begin d = q2_dat[i]; c = q2_cyc[i]; l = q2_last[i]; end
      chk({tag, "_dat"}, d, ed);
      chk({tag, "_cyc"}, c, ec);
      chk({tag, "_last"}, l, el);
   endtask

   task automatic beat(input int d, input bit rd, input int b, output int bc);
      pe_out_en  = 1'b1;
      pe_dat     = DAT_W'(d);
      bias_rd_en = rd;
      bias_req   = BIAS_W'(b);
      bc         = cyc;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      pe_out_en  = 1'b0;
      bias_rd_en = 1'b0;
      bias_req   = '0;
      calc_en    = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic flush();
      calc_en = 1'b1;
      @(posedge clk); #1;
      calc_en = 1'b0;
   endtask

   task automatic clrq();
      q1_dat.delete(); q1_cyc.delete(); q1_last.delete();
      q2_dat.delete(); q2_cyc.delete(); q2_last.delete();
   endtask

   initial begin
      int bc, b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", vld1, 0);
      chk("rst_dat", dat1, 0);
      chk("rst_last", last1, 0);
      chk("rst_err", err1, 0);
      rst_n = 1'b1;
      idle(2);
      flush();
      idle(1);

      // P=1, shift 0: 10+5, -20+5, 100+30 saturates to 127
      clrq();
      beat(10, 1, 5, b0);
      beat(-20, 1, 5, bc);
      beat(100, 1, 30, bc);
      idle(6);
      chk("t1_cnt", q1_dat.size(), 3);
      chk_r(1, "t1_r0", 0, 15, b0 + 3, 1);
      chk_r(1, "t1_r1", 1, -15, b0 + 4, 1);
      chk_r(1, "t1_r2", 2, 127, b0 + 5, 1);

      // P=3, shift 2: 7+8+9-2 = 22 -> (22+2)>>>2 = 6
      part_num = 5'd3; shift = 5'd2;
      flush(); clrq();
      beat(7, 0, 0, bc); idle(1);
      beat(8, 0, 0, bc); idle(2);
      beat(9, 1, -2, b0); idle(6);
      chk("t2_cnt", q1_dat.size(), 1);
      chk_r(1, "t2_r0", 0, 6, b0 + 3, 1);

      // ReLU on then off: -50+10 = -40
      part_num = 5'd1; shift = 5'd0; relu_en = 1'b1;
      flush(); clrq();
      beat(-50, 1, 10, b0); idle(6);
      relu_en = 1'b0;
      beat(-50, 1, 10, bc); idle(6);
      chk("t3_cnt", q1_dat.size(), 2);
      chk_r(1, "t3_relu", 0, 0, b0 + 3, 1);
      chk_r(1, "t3_norelu", 1, -40, bc + 3, 1);

      // Latency 2, groups of 4: beat 10*i with bias -i gives 9*i
      output_layers = 8'd4;
      flush(); clrq();
      for (int i = 1; i <= 8; i++) begin
         beat(10 * i, 1, -i, bc);
         if (i == 1) b0 = bc;
      end
      idle(8);
      chk("t4_cnt", q2_dat.size(), 8);
      for (int i = 1; i <= 8; i++)
         chk_r(2, $sformatf("t4_r%0d", i), i - 1, 9 * i, b0 + 3 + i, (i % 4 == 0) ? 1 : 0);

      // Flush after 2 of 3 parts; the beat in the flush cycle is dropped
      output_layers = 8'd1; part_num = 5'd3;
      flush(); clrq();
      beat(100, 0, 0, bc);
      beat(100, 0, 0, bc);
      calc_en = 1'b1;
      beat(1000, 1, 55, bc);
      calc_en = 1'b0;
      beat(1, 0, 0, bc);
      beat(2, 0, 0, bc);
      beat(3, 1, 0, b0);
      idle(6);
      chk("t5_cnt", q1_dat.size(), 1);
      chk_r(1, "t5_r0", 0, 6, b0 + 3, 1);

      // Reset with two results in flight
      part_num = 5'd1;
      flush(); clrq();
      beat(5, 1, 0, bc);
      beat(6, 1, 0, bc);
      pe_out_en = 1'b0; bias_rd_en = 1'b0; rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(6);
      chk("t6_cnt1", q1_dat.size(), 0);
      chk("t6_cnt2", q2_dat.size(), 0);
      chk("t6_err", err1, 0);

      // Final beat without bias read: error flag, bias bus ignored
      flush(); clrq();
      chk("t7_err0", err1, 0);
      beat(33, 0, 77, b0);
      idle(6);
      chk("t7_cnt", q1_dat.size(), 1);
      chk_r(1, "t7_r0", 0, 33, b0 + 3, 1);
      chk("t7_err1", err1, 1);
      flush();
      idle(1);
      chk("t7_errclr", err1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
